// File: rtl/bist_pkg.sv
// Shared definitions for the BIST scheduler: FSM encoding and default sizing.
// BIST_SCHED_TIMEOUT_EN adds the TIMEOUT state.
package bist_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_SIG_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_RUN     = 3'd3,
    S_CHECK   = 3'd4
`ifdef BIST_SCHED_TIMEOUT_EN
    , S_TIMEOUT = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bist_scheduler.sv
// Time-shares one BIST controller/TPG/MISR among NUM_CORES requesters and
// records per-core done/pass. BIST_SCHED_TIMEOUT_EN adds a session watchdog.
module bist_scheduler
  import bist_pkg::*;
#(
  parameter int NUM_CORES      = DEF_NUM_CORES,
  parameter int SIG_W          = DEF_SIG_W,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CORES-1:0]       req,
  output logic [NUM_CORES-1:0]       grant,
  output logic                       bist_start,
  input  logic                       bist_end,
  input  logic [SIG_W-1:0]           signature,
  input  logic [NUM_CORES*SIG_W-1:0] golden,
  output logic [NUM_CORES-1:0]       done,
  output logic [NUM_CORES-1:0]       pass,
`ifdef BIST_SCHED_TIMEOUT_EN
  output logic [NUM_CORES-1:0]       timeout_err,
`endif
  output logic                       busy
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  if (NUM_CORES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("bist_scheduler: NUM_CORES must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  state_e                            state_q, state_d;
  logic [NUM_CORES-1:0]              grant_q, grant_d;
  logic                              start_q, start_d;
  logic                              busy_q, busy_d;
  logic [NUM_CORES-1:0]              done_q, done_d;
  logic [NUM_CORES-1:0]              pass_q, pass_d;
  logic [PW-1:0]                     ptr_q, ptr_d;
  logic [PW-1:0]                     owner_q, owner_d;
  logic [NUM_CORES-1:0]              pick;
  logic [PW-1:0]                     pick_idx;
  logic [PW-1:0]                     nxt_ptr;
  logic [NUM_CORES-1:0][SIG_W-1:0]   gold_a;

  assign gold_a = golden;

  rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  assign nxt_ptr = (owner_q == PW'(NUM_CORES - 1)) ? '0 : owner_q + 1'b1;

`ifdef BIST_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  // START counts toward the budget, so TIMEOUT registers exactly
  // TIMEOUT_CYCLES cycles after the start pulse.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_CORES-1:0] terr_q, terr_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    start_d = 1'b0;
    done_d  = done_q;
    pass_d  = pass_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
`ifdef BIST_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    terr_d  = terr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d          = S_START;
          grant_d          = pick;
          owner_d          = pick_idx;
          start_d          = 1'b1;
          done_d[pick_idx] = 1'b0;
          pass_d[pick_idx] = 1'b0;
`ifdef BIST_SCHED_TIMEOUT_EN
          terr_d[pick_idx] = 1'b0;
`endif
        end
      end
      S_START: begin
        state_d = S_WAIT_LO;
`ifdef BIST_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      // A stale end level from the previous session must drop first.
      S_WAIT_LO: begin
        if (!bist_end) state_d = S_RUN;
`ifdef BIST_SCHED_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
      end
      // Signature is sampled on the edge where bist_end is seen high.
      S_RUN: begin
        if (bist_end) begin
          state_d         = S_CHECK;
          pass_d[owner_q] = (signature == gold_a[owner_q]);
          done_d[owner_q] = 1'b1;
          grant_d         = '0;
          ptr_d           = nxt_ptr;
        end
`ifdef BIST_SCHED_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
      end
      S_CHECK: state_d = S_IDLE;
`ifdef BIST_SCHED_TIMEOUT_EN
      S_TIMEOUT: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef BIST_SCHED_TIMEOUT_EN
    // Normal completion wins over a watchdog expiry in the same cycle.
    if ((state_q == S_WAIT_LO || state_q == S_RUN) && state_d != S_CHECK &&
        cnt_q == TO_LAST) begin
      state_d         = S_TIMEOUT;
      done_d[owner_q] = 1'b1;
      pass_d[owner_q] = 1'b0;
      terr_d[owner_q] = 1'b1;
      grant_d         = '0;
      ptr_d           = nxt_ptr;
    end
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      pass_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
`ifdef BIST_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
`ifdef BIST_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign bist_start = start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
`ifdef BIST_SCHED_TIMEOUT_EN
  assign timeout_err = terr_q;
`endif

endmodule

// File: tb/tb_bist_scheduler.sv
// Directed bench for bist_scheduler: single session, mismatch, fairness,
// stale end level, mid-session reset, and (when enabled) watchdog expiry.
module tb_bist_scheduler;

  localparam int NC = 4;
  localparam int SW = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     req = '0;
  logic [NC-1:0]     grant;
  logic              bist_start;
  logic              bist_end = 1'b0;
  logic [SW-1:0]     signature = '0;
  logic [NC*SW-1:0]  golden = {16'h4444, 16'hBEEE, 16'h2222, 16'h1111};
  logic [NC-1:0]     done;
  logic [NC-1:0]     pass;
  logic              busy;
`ifdef BIST_SCHED_TIMEOUT_EN
  logic [NC-1:0]     timeout_err;
`endif

  int            n_chk = 0;
  int            n_fail = 0;
  logic [NC-1:0] exp_done = '0;
  logic [NC-1:0] exp_pass = '0;

  bist_scheduler #(.NUM_CORES(NC), .SIG_W(SW), .TIMEOUT_CYCLES(50)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .bist_start (bist_start),
    .bist_end   (bist_end),
    .signature  (signature),
    .golden     (golden),
    .done       (done),
    .pass       (pass),
`ifdef BIST_SCHED_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Caller leaves the DUT in IDLE with req set; returns in IDLE.
  task automatic session(input logic [NC-1:0] g, input logic [SW-1:0] sig,
                         input bit ok, input int dly, input bit drop);
    tick;
    chk("grant", 32'(grant), 32'(g));
    chk("bist_start", 32'(bist_start), 32'd1);
    chk("busy", 32'(busy), 32'd1);
    exp_done &= ~g;
    exp_pass &= ~g;
    chk("done_clr", 32'(done), 32'(exp_done));
    if (drop) req = '0;
    tick;
    chk("start_pulse", 32'(bist_start), 32'd0);
    repeat (dly) tick;
    chk("grant_hold", 32'(grant), 32'(g));
    bist_end  = 1'b1;
    signature = sig;
    tick;
    exp_done |= g;
    if (ok) exp_pass |= g;
    chk("done", 32'(done), 32'(exp_done));
    chk("pass", 32'(pass), 32'(exp_pass));
    chk("grant_clr", 32'(grant), 32'd0);
    bist_end = 1'b0;
    tick;
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (2) tick;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_start", 32'(bist_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    reset = 1'b0;
    tick;

    // Single request, end 1060 cycles after start, req dropped mid-session
    req = 4'b0001;
    session(4'b0001, 16'h1111, 1'b1, 1058, 1'b1);

    // Signature mismatch on core 2
    req = 4'b0100;
    session(4'b0100, 16'hBEEF, 1'b0, 20, 1'b1);

    // Fairness from a freshly reset pointer
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_done = '0;
    exp_pass = '0;
    req = 4'b1111;
    session(4'b0001, 16'h1111, 1'b1, 3, 1'b0);
    session(4'b0010, 16'h0000, 1'b0, 3, 1'b0);
    session(4'b0100, 16'hBEEE, 1'b1, 3, 1'b0);
    session(4'b1000, 16'h4444, 1'b1, 3, 1'b0);
    session(4'b0001, 16'h1111, 1'b1, 3, 1'b1);

    // Stale end level held from the previous session
    bist_end  = 1'b1;
    signature = 16'h2222;
    req = 4'b0010;
    tick;
    chk("stale_grant", 32'(grant), 32'b0010);
    exp_done &= ~4'b0010;
    exp_pass &= ~4'b0010;
    req = '0;
    repeat (6) tick;
    chk("stale_wait_done", 32'(done), 32'(exp_done));
    chk("stale_wait_busy", 32'(busy), 32'd1);
    bist_end = 1'b0;
    repeat (3) tick;
    chk("stale_run_done", 32'(done), 32'(exp_done));
    chk("stale_run_grant", 32'(grant), 32'b0010);
    bist_end = 1'b1;
    tick;
    exp_done |= 4'b0010;
    exp_pass |= 4'b0010;
    chk("stale_done", 32'(done), 32'(exp_done));
    chk("stale_pass", 32'(pass), 32'(exp_pass));
    bist_end = 1'b0;
    tick;

    // Reset 100 cycles into a session
    req = 4'b1000;
    tick;
    chk("mid_grant", 32'(grant), 32'b1000);
    req = '0;
    repeat (99) tick;
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_pass", 32'(pass), 32'd0);
    reset = 1'b0;
    exp_done = '0;
    exp_pass = '0;
    tick;

`ifdef BIST_SCHED_TIMEOUT_EN
    begin
      int n;
      n = 0;
      req = 4'b0001;
      tick;
      req = '0;
      while (timeout_err[0] !== 1'b1 && n < 80) begin
        tick;
        n++;
      end
      chk("to_latency", 32'(n), 32'd50);
      chk("to_err", 32'(timeout_err), 32'b0001);
      chk("to_done", 32'(done), 32'b0001);
      chk("to_pass", 32'(pass), 32'd0);
      chk("to_grant", 32'(grant), 32'd0);
      tick;
      chk("to_idle", 32'(busy), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
